digit_plot_sequencer: RTL and testbench

- Sequences the glyph stroke ROM (`number`) to draw a multi-digit decimal value.
- For each digit it walks the stroke index from 0 and registers each stroke.
- Each stroke is translated to the digit's screen position and handed to the downstream line-drawing engine over a valid/ready handshake.
- Sits between the display/score logic (start, digits, origin) and the line rasteriser.

---
 rtl/digit_plot_sequencer.sv | 236 +++++++++++++++++++++++
 tb/tb_digit_plot_sequencer.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/digit_plot_sequencer.sv
// rtl/digit_plot_sequencer.sv - walks the glyph stroke ROM and issues translated segments per digit
//
// Purpose:
//   Draws a multi-digit decimal value by stepping through each captured BCD
//   digit, reading its strokes from the glyph ROM one index at a time, and
//   handing each stroke (offset to the digit's screen position) to the line
//   rasteriser over a valid/ready handshake.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   start, abort             draw request (IDLE only) / synchronous cancel
//   digits, num_digits       BCD digits (digit 0 leftmost) and count to draw
//   origin_x, origin_y       screen position of digit 0
//   pitch                    x advance between digits
//   rom_idx, rom_select      glyph ROM address (stroke index, digit value)
//   rom_start_*, rom_end_*   glyph ROM stroke endpoints (combinational)
//   rom_pen_down             glyph ROM pen flag
//   seg_valid, seg_ready     segment handshake to the line engine
//   seg_x0..seg_y1, seg_pen  translated segment
//   busy, done               activity flag / one-cycle completion pulse

module digit_plot_sequencer #(
    parameter int MAX_DIGITS = 4,
    parameter int CW         = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    abort,
    input  logic [4*MAX_DIGITS-1:0] digits,
    input  logic [2:0]              num_digits,
    input  logic [CW-1:0]           origin_x,
    input  logic [CW-1:0]           origin_y,
    input  logic [7:0]              pitch,
    output logic [4:0]              rom_idx,
    output logic [3:0]              rom_select,
    input  logic [7:0]              rom_start_x,
    input  logic [7:0]              rom_start_y,
    input  logic [7:0]              rom_end_x,
    input  logic [7:0]              rom_end_y,
    input  logic                    rom_pen_down,
    output logic                    seg_valid,
    input  logic                    seg_ready,
    output logic [CW-1:0]           seg_x0,
    output logic [CW-1:0]           seg_y0,
    output logic [CW-1:0]           seg_x1,
    output logic [CW-1:0]           seg_y1,
    output logic                    seg_pen,
    output logic                    busy,
    output logic                    done
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_ISSUE = 3'd2,
        S_NEXT  = 3'd3,
        S_FIN   = 3'd4
    } state_t;

    localparam int          PAD      = CW - 8;
    localparam logic [2:0]  ND_MAX   = 3'(MAX_DIGITS);
    localparam logic [4:0]  IDX_LAST = 5'd31;

    state_t state_q, state_d;

    // Values captured at start; the live inputs are ignored until the next start.
    logic [4*MAX_DIGITS-1:0] digits_q;
    logic [2:0]              nd_q;
    logic [CW-1:0]           oy_q;
    logic [7:0]              pitch_q;

    // Walk position: digit counter, stroke index and current digit's x base.
    logic [2:0]              d_q;
    logic [4:0]              idx_q;
    logic [CW-1:0]           base_x_q;

    // Registered segment presented to the line engine.
    logic [CW-1:0]           seg_x0_q, seg_y0_q, seg_x1_q, seg_y1_q;
    logic                    seg_pen_q;

    logic [2:0]              nd_clamp;
    logic [3:0]              cur_digit;
    logic                    is_term;
    logic                    accept;
    logic                    last_digit;

    // Larger requests than the digit field holds are drawn as MAX_DIGITS.
    always_comb begin
        nd_clamp = num_digits;
        if (int'(num_digits) > MAX_DIGITS) begin
            nd_clamp = ND_MAX;
        end
    end

    // Digit value currently being drawn, selected by the digit counter.
    always_comb begin
        cur_digit = 4'd0;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            if (d_q == 3'(i)) begin
                cur_digit = digits_q[4*i +: 4];
            end
        end
    end

    // An all-zero pen-up stroke marks the end of a glyph. A pen-down stroke
    // at the origin is still a real (zero-length) segment.
    assign is_term = !rom_pen_down
                  && (rom_start_x == 8'd0) && (rom_start_y == 8'd0)
                  && (rom_end_x   == 8'd0) && (rom_end_y   == 8'd0);

    // abort outranks a same-cycle handshake, so the segment is not consumed.
    assign accept     = (state_q == S_ISSUE) && seg_ready && !abort;
    assign last_digit = ((d_q + 3'd1) == nd_q);

    // ---------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------
    // FSM: next-state logic
    // ---------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = (nd_clamp == 3'd0) ? S_FIN : S_FETCH;
                end
            end
            S_FETCH: begin
                state_d = is_term ? S_NEXT : S_ISSUE;
            end
            S_ISSUE: begin
                if (seg_ready) begin
                    state_d = (idx_q == IDX_LAST) ? S_NEXT : S_FETCH;
                end
            end
            S_NEXT: begin
                state_d = last_digit ? S_FIN : S_FETCH;
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
        end
    end

    // ---------------------------------------------------------------
    // FSM: outputs
    // ---------------------------------------------------------------
    always_comb begin
        seg_valid = (state_q == S_ISSUE);
        busy      = (state_q != S_IDLE);
        done      = (state_q == S_FIN) && !abort;
    end

    // ---------------------------------------------------------------
    // Datapath
    // ---------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digits_q  <= '0;
            nd_q      <= 3'd0;
            oy_q      <= '0;
            pitch_q   <= 8'd0;
            d_q       <= 3'd0;
            idx_q     <= 5'd0;
            base_x_q  <= '0;
            seg_x0_q  <= '0;
            seg_y0_q  <= '0;
            seg_x1_q  <= '0;
            seg_y1_q  <= '0;
            seg_pen_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        digits_q <= digits;
                        nd_q     <= nd_clamp;
                        oy_q     <= origin_y;
                        pitch_q  <= pitch;
                        d_q      <= 3'd0;
                        idx_q    <= 5'd0;
                        base_x_q <= origin_x;
                    end
                end
                S_FETCH: begin
                    // Translation wraps at CW bits by construction.
                    if (!is_term) begin
                        seg_x0_q  <= {{PAD{1'b0}}, rom_start_x} + base_x_q;
                        seg_y0_q  <= {{PAD{1'b0}}, rom_start_y} + oy_q;
                        seg_x1_q  <= {{PAD{1'b0}}, rom_end_x}   + base_x_q;
                        seg_y1_q  <= {{PAD{1'b0}}, rom_end_y}   + oy_q;
                        seg_pen_q <= rom_pen_down;
                    end
                end
                S_ISSUE: begin
                    if (accept && (idx_q != IDX_LAST)) begin
                        idx_q <= idx_q + 5'd1;
                    end
                end
                S_NEXT: begin
                    if (!abort) begin
                        d_q      <= d_q + 3'd1;
                        idx_q    <= 5'd0;
                        base_x_q <= base_x_q + {{PAD{1'b0}}, pitch_q};
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign rom_idx    = idx_q;
    assign rom_select = cur_digit;
    assign seg_x0     = seg_x0_q;
    assign seg_y0     = seg_y0_q;
    assign seg_x1     = seg_x1_q;
    assign seg_y1     = seg_y1_q;
    assign seg_pen    = seg_pen_q;

endmodule

// File: tb/tb_digit_plot_sequencer.sv
// tb/tb_digit_plot_sequencer.sv - directed self-checking bench for digit_plot_sequencer

module tb_digit_plot_sequencer;

    localparam int MAX_DIGITS = 4;
    localparam int CW         = 10;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    start;
    logic                    abort;
    logic [4*MAX_DIGITS-1:0] digits;
    logic [2:0]              num_digits;
    logic [CW-1:0]           origin_x;
    logic [CW-1:0]           origin_y;
    logic [7:0]              pitch;
    logic [4:0]              rom_idx;
    logic [3:0]              rom_select;
    logic [7:0]              rom_start_x, rom_start_y, rom_end_x, rom_end_y;
    logic                    rom_pen_down;
    logic                    seg_valid;
    logic                    seg_ready;
    logic [CW-1:0]           seg_x0, seg_y0, seg_x1, seg_y1;
    logic                    seg_pen;
    logic                    busy;
    logic                    done;

    int n_checks = 0;
    int n_pass   = 0;

    logic [63:0] seg_q[$];
    logic [63:0] exp_q[$];
    int          done_cnt = 0;

    digit_plot_sequencer #(.MAX_DIGITS(MAX_DIGITS), .CW(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .digits       (digits),
        .num_digits   (num_digits),
        .origin_x     (origin_x),
        .origin_y     (origin_y),
        .pitch        (pitch),
        .rom_idx      (rom_idx),
        .rom_select   (rom_select),
        .rom_start_x  (rom_start_x),
        .rom_start_y  (rom_start_y),
        .rom_end_x    (rom_end_x),
        .rom_end_y    (rom_end_y),
        .rom_pen_down (rom_pen_down),
        .seg_valid    (seg_valid),
        .seg_ready    (seg_ready),
        .seg_x0       (seg_x0),
        .seg_y0       (seg_y0),
        .seg_x1       (seg_x1),
        .seg_y1       (seg_y1),
        .seg_pen      (seg_pen),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    // Small glyph table: 1 = 2 strokes, 2 = 3 strokes (last is a pen-down
    // zero-length stroke), 3 = 1 stroke, 8 = 32 strokes with no terminator.
    function automatic logic [32:0] rom_f(input logic [3:0] g, input logic [4:0] i);
        logic [7:0] i8;
        i8 = {3'b0, i};
        case (g)
            4'd1: case (i)
                5'd0:    return {8'd2,  8'd0,  8'd2,  8'd20, 1'b1};
                5'd1:    return {8'd2,  8'd20, 8'd10, 8'd30, 1'b0};
                default: return 33'd0;
            endcase
            4'd2: case (i)
                5'd0:    return {8'd0,  8'd0,  8'd10, 8'd0,  1'b1};
                5'd1:    return {8'd10, 8'd0,  8'd10, 8'd20, 1'b1};
                5'd2:    return {8'd0,  8'd0,  8'd0,  8'd0,  1'b1};
                default: return 33'd0;
            endcase
            4'd3: case (i)
                5'd0:    return {8'd10, 8'd5,  8'd0,  8'd5,  1'b1};
                default: return 33'd0;
            endcase
            4'd8:        return {i8, i8, i8 + 8'd1, i8, 1'b1};
            default:     return 33'd0;
        endcase
    endfunction

    always_comb begin
        {rom_start_x, rom_start_y, rom_end_x, rom_end_y, rom_pen_down} = rom_f(rom_select, rom_idx);
    end

    function automatic logic [63:0] pk(input int idx, input int x0, input int y0,
                                       input int x1, input int y1, input int pen);
        return {18'b0, 5'(idx), 10'(x0), 10'(y0), 10'(x1), 10'(y1), 1'(pen)};
    endfunction

    // Record every segment that will be consumed at the coming edge.
    always @(negedge clk) begin
        if (seg_valid && seg_ready && !abort) begin
            seg_q.push_back(pk(int'(rom_idx), int'(seg_x0), int'(seg_y0),
                               int'(seg_x1), int'(seg_y1), int'(seg_pen)));
        end
        if (done) begin
            done_cnt++;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_start();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int b;
        b = done_cnt;
        for (int k = 0; k < budget && done_cnt == b; k++) begin
            @(negedge clk);
        end
        repeat (3) @(posedge clk);
        #1;
        check({tag, " done once"}, 64'(done_cnt - b), 64'd1);
    endtask

    task automatic verify(input string tag, input int base);
        check({tag, " seg count"}, 64'(seg_q.size() - base), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (base + i < seg_q.size()) begin
                check($sformatf("%s seg%0d", tag, i), seg_q[base + i], exp_q[i]);
            end else begin
                check($sformatf("%s seg%0d missing", tag, i), 64'd0, exp_q[i]);
            end
        end
    endtask

    task automatic setup(input logic [15:0] dg, input int nd, input int ox,
                         input int oy, input int pt);
        digits     = dg;
        num_digits = 3'(nd);
        origin_x   = 10'(ox);
        origin_y   = 10'(oy);
        pitch      = 8'(pt);
    endtask

    initial begin
        int base;
        int dbase;

        rst = 1'b1; start = 1'b0; abort = 1'b0; seg_ready = 1'b0;
        setup(16'h0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        check("reset seg_valid", 64'(seg_valid), 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset rom_idx", 64'(rom_idx), 64'd0);
        check("reset rom_select", 64'(rom_select), 64'd0);
        check("reset seg_x0", 64'(seg_x0), 64'd0);
        rst = 1'b0;

        // Asynchronous reset while stalled on the second segment of glyph 2.
        base = seg_q.size(); dbase = done_cnt;
        setup(16'h0002, 1, 100, 50, 40);
        seg_ready = 1'b1;
        do_start();
        @(posedge clk); #1;
        seg_ready = 1'b1;
        @(posedge clk); #1;
        seg_ready = 1'b0;
        @(posedge clk); #1;
        check("rst pre valid", 64'(seg_valid), 64'd1);
        check("rst pre rom_idx", 64'(rom_idx), 64'd1);
        check("rst pre seg_x0", 64'(seg_x0), 64'd110);
        #2 rst = 1'b1;
        #1;
        check("rst async seg_valid", 64'(seg_valid), 64'd0);
        check("rst async busy", 64'(busy), 64'd0);
        check("rst async rom_idx", 64'(rom_idx), 64'd0);
        #2 rst = 1'b0;
        seg_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("rst no done", 64'(done_cnt - dbase), 64'd0);
        check("rst seg count", 64'(seg_q.size() - base), 64'd1);

        // Two digits "12": latency, translation, index restart, done.
        base = seg_q.size();
        setup(16'h0021, 2, 100, 50, 40);
        seg_ready = 1'b1;
        do_start();
        check("t2 valid at +1", 64'(seg_valid), 64'd0);
        check("t2 busy at +1", 64'(busy), 64'd1);
        @(posedge clk); #1;
        check("t2 valid at +2", 64'(seg_valid), 64'd1);
        wait_done("t2", 100);
        exp_q = {};
        exp_q.push_back(pk(0, 102, 50, 102, 70, 1));
        exp_q.push_back(pk(1, 102, 70, 110, 80, 0));
        exp_q.push_back(pk(0, 140, 50, 150, 50, 1));
        exp_q.push_back(pk(1, 150, 50, 150, 70, 1));
        exp_q.push_back(pk(2, 140, 50, 140, 50, 1));
        verify("t2", base);

        // Same draw with a 5-cycle stall on the second segment.
        base = seg_q.size();
        seg_ready = 1'b1;
        do_start();
        @(posedge clk); #1;
        @(posedge clk); #1;
        seg_ready = 1'b0;
        @(posedge clk); #1;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("t3 stall%0d valid", k), 64'(seg_valid), 64'd1);
            check($sformatf("t3 stall%0d seg", k),
                  pk(int'(rom_idx), int'(seg_x0), int'(seg_y0), int'(seg_x1), int'(seg_y1), int'(seg_pen)),
                  pk(1, 102, 70, 110, 80, 0));
            if (k < 4) begin
                @(posedge clk); #1;
            end
        end
        seg_ready = 1'b1;
        wait_done("t3", 100);
        verify("t3", base);

        // num_digits = 0: straight to FIN.
        base = seg_q.size(); dbase = done_cnt;
        setup(16'h0021, 0, 100, 50, 40);
        do_start();
        check("t4 done at +1", 64'(done), 64'd1);
        check("t4 valid at +1", 64'(seg_valid), 64'd0);
        @(posedge clk); #1;
        check("t4 done cleared", 64'(done), 64'd0);
        check("t4 idle", 64'(busy), 64'd0);
        check("t4 no segs", 64'(seg_q.size() - base), 64'd0);
        check("t4 done once", 64'(done_cnt - dbase), 64'd1);

        // Non-BCD second digit draws nothing.
        base = seg_q.size();
        setup(16'h00F3, 2, 200, 100, 16);
        do_start();
        wait_done("t4b", 100);
        exp_q = {};
        exp_q.push_back(pk(0, 210, 105, 200, 105, 1));
        verify("t4b", base);

        // Non-BCD first digit still advances the x base.
        base = seg_q.size();
        setup(16'h001F, 2, 0, 0, 30);
        do_start();
        wait_done("t4c", 100);
        exp_q = {};
        exp_q.push_back(pk(0, 32, 0, 32, 20, 1));
        exp_q.push_back(pk(1, 32, 20, 40, 30, 0));
        verify("t4c", base);

        // Coordinate wrap at 1024.
        base = seg_q.size();
        setup(16'h0003, 1, 1020, 1020, 0);
        do_start();
        wait_done("t5", 100);
        exp_q = {};
        exp_q.push_back(pk(0, 6, 1, 1020, 1, 1));
        verify("t5", base);

        // num_digits above MAX_DIGITS clamps to four digits.
        base = seg_q.size();
        setup(16'h3333, 7, 0, 0, 100);
        do_start();
        wait_done("clamp", 200);
        exp_q = {};
        exp_q.push_back(pk(0, 10, 5, 0, 5, 1));
        exp_q.push_back(pk(0, 110, 5, 100, 5, 1));
        exp_q.push_back(pk(0, 210, 5, 200, 5, 1));
        exp_q.push_back(pk(0, 310, 5, 300, 5, 1));
        verify("clamp", base);

        // Glyph with 32 strokes ends at idx 31 without a terminator.
        base = seg_q.size();
        setup(16'h0008, 1, 0, 0, 0);
        do_start();
        wait_done("idx31", 400);
        check("idx31 count", 64'(seg_q.size() - base), 64'd32);
        if (seg_q.size() >= base + 32) begin
            check("idx31 first", seg_q[base], pk(0, 0, 0, 1, 0, 1));
            check("idx31 last", seg_q[base + 31], pk(31, 31, 31, 32, 31, 1));
        end

        // abort with seg_ready in the same cycle during a stall.
        base = seg_q.size(); dbase = done_cnt;
        setup(16'h0002, 1, 100, 50, 40);
        seg_ready = 1'b0;
        do_start();
        @(posedge clk); #1;
        check("t6 stalled valid", 64'(seg_valid), 64'd1);
        abort = 1'b1;
        seg_ready = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("t6 abort valid", 64'(seg_valid), 64'd0);
        check("t6 abort busy", 64'(busy), 64'd0);
        repeat (4) @(posedge clk);
        #1;
        check("t6 no segs", 64'(seg_q.size() - base), 64'd0);
        check("t6 no done", 64'(done_cnt - dbase), 64'd0);

        // start and new inputs while busy are ignored.
        base = seg_q.size();
        setup(16'h0001, 1, 0, 0, 0);
        seg_ready = 1'b1;
        do_start();
        setup(16'h0003, 1, 500, 0, 0);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("t6b", 100);
        exp_q = {};
        exp_q.push_back(pk(0, 2, 0, 2, 20, 1));
        exp_q.push_back(pk(1, 2, 20, 10, 30, 0));
        verify("t6b", base);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
